regfile_writeback: RTL and testbench

Writeback stage that drives the single register-file write port (write enable, rd address, write data). It merges two sources: single-cycle ALU results and variable-latency load returns. Load data is extended and byte-aligned, then buffered in a small queue while the ALU owns the port. It also keeps a per-register pending scoreboard for outstanding loads, which issue logic uses for load-use stalls.

---
 rtl/regfile_writeback.sv | 144 ++++++++++++++
 tb/tb_regfile_writeback.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback: merges ALU results with queued, formatted load returns
// and tracks outstanding loads per destination register.
module regfile_writeback #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [4:0]                  ld_rd,
  input  logic [2:0]                  ld_funct3,
  input  logic [1:0]                  ld_byte_off,
  input  logic [XLEN-1:0]             ld_word,
  input  logic                        ld_issue,
  input  logic [4:0]                  ld_issue_rd,
  output logic                        wb_wr_en,
  output logic [4:0]                  wb_rd,
  output logic [XLEN-1:0]             wb_data,
  output logic [31:0]                 rd_pending,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } lq_entry_t;

  lq_entry_t             lq_q [LQ_DEPTH];
  lq_entry_t             lq_d [LQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wb_wr_en_q, wb_wr_en_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [31:0]           pend_q, pend_d;

  logic [XLEN-1:0]       ld_sh;
  logic [XLEN-1:0]       ld_fmt;
  logic                  alu_win;
  logic                  push;
  logic                  pop;
  lq_entry_t             head;

  assign ld_ready = (count_q < CNT_W'(LQ_DEPTH));

  // Load data extension/alignment; halfword at offset 3 simply takes what the shift yields
  always_comb begin
    ld_sh  = ld_word >> {ld_byte_off, 3'b000};
    ld_fmt = '0;
    case (ld_funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_fmt = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_fmt = ld_word;
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
      default: ld_fmt = '0;
    endcase
  end

  // ALU has priority; a dropped x0 ALU result does not block a queue pop
  always_comb begin
    alu_win    = alu_valid && (alu_rd != 5'd0);
    pop        = !alu_win && (count_q != '0);
    push       = ld_valid && ld_ready && (ld_rd != 5'd0);
    head       = lq_q[rd_ptr_q];

    lq_d       = lq_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wb_wr_en_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    pend_d     = pend_q;

    if (push) begin
      lq_d[wr_ptr_q] = '{rd: ld_rd, data: ld_fmt};
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
    end

    if (alu_win) begin
      wb_wr_en_d = 1'b1;
      wb_rd_d    = alu_rd;
      wb_data_d  = alu_data;
    end else if (pop) begin
      wb_wr_en_d      = 1'b1;
      wb_rd_d         = head.rd;
      wb_data_d       = head.data;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      pend_d[head.rd] = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new issue on the clearing edge wins over the clear
    if (ld_issue && (ld_issue_rd != 5'd0)) begin
      pend_d[ld_issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        lq_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wb_wr_en_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      pend_q     <= '0;
    end else begin
      lq_q       <= lq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wb_wr_en_q <= wb_wr_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      pend_q     <= pend_d;
    end
  end

  assign wb_wr_en   = wb_wr_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign rd_pending = pend_q;
  assign lq_count   = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes are queued as stimulus is
// issued and a negedge monitor checks every register-file write against them.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_off;
  logic [31:0] ld_word;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        wb_wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rd_pending;
  logic [1:0]  lq_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  regfile_writeback #(.XLEN(32), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_byte_off(ld_byte_off), .ld_word(ld_word),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_pending(rd_pending), .lq_count(lq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (wb_wr_en) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_wb got rd=%0d data=%h", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          bad++;
          $display("FAIL wb_write got rd=%0d data=%h want rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] w);
    ld_valid    = v;
    ld_rd       = rd;
    ld_funct3   = f3;
    ld_byte_off = off;
    ld_word     = w;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  // Issue-side rule: no second load to a register still pending (unless it clears this edge)
  task automatic issue(input logic [4:0] rd, input logic clearing_now);
    if (!clearing_now) chk("issue_not_pending", 32'(rd_pending[rd]), 32'd0);
    ld_issue    = 1'b1;
    ld_issue_rd = rd;
  endtask

  logic [2:0]  f3_v  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b001};
  logic [1:0]  off_v [7] = '{2'd0,   2'd1,   2'd2,   2'd2,   2'd3,   2'd0,   2'd3};
  logic [31:0] res_v [7] = '{32'hFFFFFF82, 32'h0000007F, 32'hFFFF80F1, 32'h000080F1,
                             32'h80F17F82, 32'h00000000, 32'h00000080};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    ld_issue    = 1'b0;
    ld_issue_rd = 5'd0;
    step();
    step();
    chk("rst_wr_en", 32'(wb_wr_en), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_lq_count", 32'(lq_count), 32'd0);
    chk("rst_pending", rd_pending, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // ALU single-cycle write, then hold
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    push_exp(5'd5, 32'hDEADBEEF);
    step();
    chk("alu_wr_en", 32'(wb_wr_en), 32'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    step();
    chk("alu_idle_wr_en", 32'(wb_wr_en), 32'd0);
    chk("alu_idle_hold_data", wb_data, 32'hDEADBEEF);
    chk("alu_idle_hold_rd", 32'(wb_rd), 32'd5);

    // Load formatting, one at a time; no bypass on the accept edge
    for (int i = 0; i < 7; i++) begin
      drive_ld(1'b1, 5'(20 + i), f3_v[i], off_v[i], 32'h80F17F82);
      push_exp(5'(20 + i), res_v[i]);
      step();
      chk("fmt_lq_count", 32'(lq_count), 32'd1);
      chk("fmt_no_bypass", 32'(wb_wr_en), 32'd0);
      drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
      step();
      chk("fmt_popped", 32'(wb_wr_en), 32'd1);
    end
    step();

    // Contention: ALU burst rd 1..4 with loads 10,11,12
    push_exp(5'd1, 32'h101);
    push_exp(5'd2, 32'h102);
    push_exp(5'd3, 32'h103);
    push_exp(5'd4, 32'h104);
    push_exp(5'd10, 32'hA0A0_0010);
    push_exp(5'd11, 32'hA0A0_0011);
    push_exp(5'd12, 32'hA0A0_0012);
    drive_alu(1'b1, 5'd1, 32'h101);
    drive_ld(1'b1, 5'd10, 3'b010, 2'd0, 32'hA0A0_0010);
    step();
    drive_alu(1'b1, 5'd2, 32'h102);
    drive_ld(1'b1, 5'd11, 3'b010, 2'd0, 32'hA0A0_0011);
    step();
    chk("cont_full_count", 32'(lq_count), 32'd2);
    drive_alu(1'b1, 5'd3, 32'h103);
    drive_ld(1'b1, 5'd12, 3'b010, 2'd0, 32'hA0A0_0012);
    chk("cont_full_ready_c2", 32'(ld_ready), 32'd0);
    step();
    drive_alu(1'b1, 5'd4, 32'h104);
    chk("cont_full_ready_c3", 32'(ld_ready), 32'd0);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("cont_pop_cycle_ready", 32'(ld_ready), 32'd0);
    step();
    chk("cont_after_pop_ready", 32'(ld_ready), 32'd1);
    step();
    chk("cont_push_pop_count", 32'(lq_count), 32'd1);
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    step();
    step();
    chk("cont_drained", 32'(lq_count), 32'd0);

    // x0 handling
    drive_ld(1'b1, 5'd15, 3'b010, 2'd0, 32'h15151515);
    push_exp(5'd15, 32'h15151515);
    step();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    drive_alu(1'b1, 5'd0, 32'h00000BAD);
    step();
    chk("x0_alu_pop_wr_en", 32'(wb_wr_en), 32'd1);
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b1, 5'd0, 3'b010, 2'd0, 32'hFFFFFFFF);
    chk("x0_ld_ready", 32'(ld_ready), 32'd1);
    step();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("x0_ld_count", 32'(lq_count), 32'd0);
    chk("x0_ld_no_wr_a", 32'(wb_wr_en), 32'd0);
    step();
    chk("x0_ld_no_wr_b", 32'(wb_wr_en), 32'd0);

    // Pending scoreboard for rd 7
    issue(5'd7, 1'b0);
    step();
    ld_issue = 1'b0;
    chk("pend_set", rd_pending, 32'h0000_0080);
    drive_alu(1'b1, 5'd7, 32'h77);
    push_exp(5'd7, 32'h77);
    step();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("pend_alu_untouched", rd_pending, 32'h0000_0080);
    drive_ld(1'b1, 5'd7, 3'b100, 2'd0, 32'h000000AB);
    push_exp(5'd7, 32'h000000AB);
    step();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("pend_held_queued", rd_pending, 32'h0000_0080);
    issue(5'd7, 1'b1);
    step();
    ld_issue = 1'b0;
    chk("pend_set_wins", rd_pending, 32'h0000_0080);
    drive_ld(1'b1, 5'd7, 3'b010, 2'd0, 32'h12345678);
    push_exp(5'd7, 32'h12345678);
    step();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    step();
    chk("pend_cleared", rd_pending, 32'd0);

    // Reset with two queued loads and bits 3, 9 pending
    issue(5'd3, 1'b0);
    step();
    issue(5'd9, 1'b0);
    step();
    ld_issue = 1'b0;
    push_exp(5'd1, 32'h201);
    push_exp(5'd2, 32'h202);
    drive_alu(1'b1, 5'd1, 32'h201);
    drive_ld(1'b1, 5'd3, 3'b010, 2'd0, 32'h33333333);
    step();
    drive_alu(1'b1, 5'd2, 32'h202);
    drive_ld(1'b1, 5'd9, 3'b010, 2'd0, 32'h99999999);
    step();
    chk("rstmid_count_pre", 32'(lq_count), 32'd2);
    chk("rstmid_pend_pre", rd_pending, 32'h0000_0208);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    #1;
    chk("rstmid_count", 32'(lq_count), 32'd0);
    chk("rstmid_pend", rd_pending, 32'd0);
    chk("rstmid_wr_en", 32'(wb_wr_en), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rstmid_post_count", 32'(lq_count), 32'd0);
    chk("rstmid_post_wr_en", 32'(wb_wr_en), 32'd0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
